// File: rtl/axi_slave_bram.sv
// axi_slave_bram: AXI burst slave backed by a 2^MEM_DEPTH_LOG2 x 32-bit block RAM.
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   SLAVE_WR_ADDR_*           write address channel (ID, byte address, LEN, BURST, VALID/READY)
//   SLAVE_WR_DATA/STRB/LAST   write data channel with byte enables (VALID/READY)
//   SLAVE_WR_BACK_*           write response channel (ID, RESP, VALID/READY)
//   SLAVE_RD_ADDR_*           read address channel (ID, byte address, LEN, BURST, VALID/READY)
//   SLAVE_RD_BACK_ID/DATA_*   read data channel (ID, DATA, RESP, LAST, VALID/READY)
// Build option: define AXI_BRAM_RANGE_CHECK_EN to reject beats outside the memory window
// (no write, SLVERR); otherwise the word index wraps modulo the depth.
module axi_slave_bram #(
    parameter int          MEM_DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [3:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [3:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [3:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY
);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int AW = MEM_DEPTH_LOG2;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    w_state_t w_state_q;
    r_state_t r_state_q;
    logic [31:0] mem [DEPTH];
    logic [31:0] waddr_q, raddr_q, rdata_q;
    logic [7:0] wlen_q, wcnt_q, rlen_q, rcnt_q;
    logic [1:0] wburst_q, rburst_q, bresp_q, rresp_q;
    logic [3:0] bid_q, rid_q;
    logic werr_q, awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
    logic [32:0] woff, roff;
    logic [AW-1:0] widx, ridx;
    logic wok, rok, w_hs, w_final, w_bad, unused_off;
    always_comb begin
        // 33-bit offsets so that addresses below BASE_ADDR show up as a set bit 32
        woff = {1'b0, waddr_q} - {1'b0, BASE_ADDR};
        roff = {1'b0, raddr_q} - {1'b0, BASE_ADDR};
        widx = woff[AW+1:2];
        ridx = roff[AW+1:2];
`ifdef AXI_BRAM_RANGE_CHECK_EN
        wok = woff[32:AW+2] == '0;
        rok = roff[32:AW+2] == '0;
`else
        wok = 1'b1;
        rok = 1'b1;
`endif
        unused_off = ^{woff[32:AW+2], woff[1:0], roff[32:AW+2], roff[1:0]};
        w_hs = w_state_q == W_DATA && wready_q && SLAVE_WR_DATA_VALID;
        w_final = wcnt_q == wlen_q;
        // LAST must coincide exactly with the LEN+1th beat
        w_bad = (SLAVE_WR_DATA_LAST != w_final) || !wok;
    end
    // memory is never reset; partially written bursts persist across rst
    always_ff @(posedge clk) begin
        if (w_hs && wok)
            for (int i = 0; i < 4; i++)
                if (SLAVE_WR_STRB[i]) mem[widx][8*i +: 8] <= SLAVE_WR_DATA[8*i +: 8];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && SLAVE_WR_ADDR_VALID) begin
                        bid_q     <= SLAVE_WR_ADDR_ID;
                        waddr_q   <= SLAVE_WR_ADDR;
                        wlen_q    <= SLAVE_WR_ADDR_LEN;
                        wburst_q  <= SLAVE_WR_ADDR_BURST;
                        wcnt_q    <= '0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wcnt_q <= wcnt_q + 8'd1;
                        werr_q <= werr_q | w_bad;
                        if (wburst_q != 2'b00) waddr_q <= waddr_q + 32'd4;
                        if (w_final) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || w_bad) ? 2'b10 : 2'b00;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (SLAVE_WR_BACK_READY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= '0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && SLAVE_RD_ADDR_VALID) begin
                        rid_q     <= SLAVE_RD_ADDR_ID;
                        raddr_q   <= SLAVE_RD_ADDR;
                        rlen_q    <= SLAVE_RD_ADDR_LEN;
                        rburst_q  <= SLAVE_RD_ADDR_BURST;
                        rcnt_q    <= '0;
                        arready_q <= 1'b0;
                        r_state_q <= R_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FETCH: begin
                    // nonblocking read of mem gives old data if a write hits the same word now
                    rdata_q   <= rok ? mem[ridx] : '0;
                    rresp_q   <= rok ? 2'b00 : 2'b10;
                    rlast_q   <= rcnt_q == rlen_q;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (SLAVE_RD_DATA_READY) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rcnt_q    <= rcnt_q + 8'd1;
                            if (rburst_q != 2'b00) raddr_q <= raddr_q + 32'd4;
                            r_state_q <= R_FETCH;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end
    assign SLAVE_WR_ADDR_READY = awready_q;
    assign SLAVE_WR_DATA_READY = wready_q;
    assign SLAVE_WR_BACK_ID    = bid_q;
    assign SLAVE_WR_BACK_RESP  = bresp_q;
    assign SLAVE_WR_BACK_VALID = bvalid_q;
    assign SLAVE_RD_ADDR_READY = arready_q;
    assign SLAVE_RD_BACK_ID    = rid_q;
    assign SLAVE_RD_DATA       = rdata_q;
    assign SLAVE_RD_DATA_RESP  = rresp_q;
    assign SLAVE_RD_DATA_LAST  = rlast_q;
    assign SLAVE_RD_DATA_VALID = rvalid_q;
endmodule

// File: tb/tb_axi_slave_bram.sv
// tb_axi_slave_bram: randomized bench for axi_slave_bram against a word-array reference model.
module tb_axi_slave_bram;
    localparam int D = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] SLAVE_WR_ADDR_ID = '0, SLAVE_RD_ADDR_ID = '0, SLAVE_WR_STRB = '0;
    logic [31:0] SLAVE_WR_ADDR = '0, SLAVE_RD_ADDR = '0, SLAVE_WR_DATA = '0;
    logic [7:0] SLAVE_WR_ADDR_LEN = '0, SLAVE_RD_ADDR_LEN = '0;
    logic [1:0] SLAVE_WR_ADDR_BURST = '0, SLAVE_RD_ADDR_BURST = '0;
    logic SLAVE_WR_ADDR_VALID = 0, SLAVE_WR_DATA_LAST = 0, SLAVE_WR_DATA_VALID = 0;
    logic SLAVE_WR_BACK_READY = 0, SLAVE_RD_ADDR_VALID = 0, SLAVE_RD_DATA_READY = 0;
    logic SLAVE_WR_ADDR_READY, SLAVE_WR_DATA_READY, SLAVE_WR_BACK_VALID;
    logic SLAVE_RD_ADDR_READY, SLAVE_RD_DATA_LAST, SLAVE_RD_DATA_VALID;
    logic [3:0] SLAVE_WR_BACK_ID, SLAVE_RD_BACK_ID;
    logic [1:0] SLAVE_WR_BACK_RESP, SLAVE_RD_DATA_RESP;
    logic [31:0] SLAVE_RD_DATA;
    logic [31:0] model [D];
    logic [31:0] wdat [256];
    logic [3:0] wstb [256];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    axi_slave_bram #(.MEM_DEPTH_LOG2(10), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
        .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
        .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
        .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_STRB(SLAVE_WR_STRB),
        .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
        .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY), .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID),
        .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP), .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID),
        .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY),
        .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID), .SLAVE_RD_ADDR(SLAVE_RD_ADDR),
        .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN), .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST),
        .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID), .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY),
        .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID), .SLAVE_RD_DATA(SLAVE_RD_DATA),
        .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP), .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST),
        .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID), .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
        return b == 2'b00 ? a : a + 32'(4 * i);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_BRAM_RANGE_CHECK_EN
        longint off;
        off = longint'(a) - longint'(BASE);
        return off >= 0 && off < 4 * D;
`else
        return a == a;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] diff;
        diff = a - BASE;
        return int'((diff / 4) % D);
    endfunction

    function automatic logic [63:0] all_outs();
        return {14'd0, SLAVE_WR_ADDR_READY, SLAVE_WR_DATA_READY, SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP,
                SLAVE_WR_BACK_VALID, SLAVE_RD_ADDR_READY, SLAVE_RD_BACK_ID, SLAVE_RD_DATA,
                SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST, SLAVE_RD_DATA_VALID};
    endfunction

    // write wdat/wstb[0..len]; LAST is driven on beat last_at (len means well-formed)
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int last_at);
        int t;
        bit bad;
        logic [31:0] ba;
        bad = last_at != len;
        SLAVE_WR_ADDR_ID = id;
        SLAVE_WR_ADDR = addr;
        SLAVE_WR_ADDR_LEN = 8'(len);
        SLAVE_WR_ADDR_BURST = burst;
        SLAVE_WR_ADDR_VALID = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!SLAVE_WR_ADDR_READY && t < 200);
        if (!SLAVE_WR_ADDR_READY) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        SLAVE_WR_ADDR_VALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            SLAVE_WR_DATA_VALID = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            ba = beat_addr(addr, burst, i);
            SLAVE_WR_DATA = wdat[i];
            SLAVE_WR_STRB = wstb[i];
            SLAVE_WR_DATA_LAST = i == last_at;
            SLAVE_WR_DATA_VALID = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!SLAVE_WR_DATA_READY && t < 200);
            if (!SLAVE_WR_DATA_READY) chk("w_timeout", 0, 1);
            @(posedge clk);
            if (in_range(ba)) begin
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) model[idx_of(ba)][8*b +: 8] = wdat[i][8*b +: 8];
            end else begin
                bad = 1'b1;
            end
            #1;
        end
        SLAVE_WR_DATA_VALID = 1'b0;
        SLAVE_WR_DATA_LAST = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        SLAVE_WR_BACK_READY = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!SLAVE_WR_BACK_VALID && t < 200);
        chk("b_valid", SLAVE_WR_BACK_VALID, 1);
        chk("b_id", SLAVE_WR_BACK_ID, id);
        chk("b_resp", SLAVE_WR_BACK_RESP, bad ? 2'b10 : 2'b00);
        @(posedge clk); #1;
        SLAVE_WR_BACK_READY = 1'b0;
        @(negedge clk);
        chk("b_drop", SLAVE_WR_BACK_VALID, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
        int t;
        logic [31:0] ba, d;
        SLAVE_RD_ADDR_ID = id;
        SLAVE_RD_ADDR = addr;
        SLAVE_RD_ADDR_LEN = 8'(len);
        SLAVE_RD_ADDR_BURST = burst;
        SLAVE_RD_ADDR_VALID = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!SLAVE_RD_ADDR_READY && t < 200);
        if (!SLAVE_RD_ADDR_READY) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        SLAVE_RD_ADDR_VALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            ba = beat_addr(addr, burst, i);
            d = in_range(ba) ? model[idx_of(ba)] : 32'h0;
            SLAVE_RD_DATA_READY = $urandom_range(0, 3) != 0;
            t = 0;
            do begin @(negedge clk); t++; end while (!SLAVE_RD_DATA_VALID && t < 200);
            chk("r_valid", SLAVE_RD_DATA_VALID, 1);
            chk("r_data", SLAVE_RD_DATA, d);
            chk("r_resp", SLAVE_RD_DATA_RESP, in_range(ba) ? 2'b00 : 2'b10);
            chk("r_last", SLAVE_RD_DATA_LAST, i == len);
            chk("r_id", SLAVE_RD_BACK_ID, id);
            if (!SLAVE_RD_DATA_READY) begin
                @(posedge clk); #1;
                SLAVE_RD_DATA_READY = 1'b1;
                @(negedge clk);
                chk("r_hold", {SLAVE_RD_DATA_VALID, SLAVE_RD_DATA}, {1'b1, d});
            end
            @(posedge clk); #1;
            SLAVE_RD_DATA_READY = 1'b0;
            @(negedge clk);
            chk("r_gap", SLAVE_RD_DATA_VALID, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i <= len; i++) begin
            wdat[i] = $urandom;
            wstb[i] = 4'(($urandom_range(0, 1) != 0) ? 15 : $urandom_range(0, 15));
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        logic [31:0] a;
        logic [1:0] bu;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        // known contents everywhere, also the 256-beat case
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            do_write(4'(k), 32'(k * 1024), 255, 2'b01, 255);
        end
        do_read(4'd9, 32'h400, 255, 2'b01);
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
        do_write(4'd5, 32'h10, 3, 2'b01, 3);
        do_read(4'd5, 32'h10, 3, 2'b01);
        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
        do_write(4'd1, 32'h0, 0, 2'b01, 0);
        wdat[0] = 32'h0000_1200; wstb[0] = 4'b0010;
        do_write(4'd1, 32'h0, 0, 2'b01, 0);
        do_read(4'd1, 32'h0, 0, 2'b01);
        for (int i = 0; i < 3; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        do_write(4'd2, 32'h8, 2, 2'b00, 2);
        do_read(4'd2, 32'h8, 1, 2'b01);
        fill_rand(1);
        do_write(4'd3, 32'h40, 1, 2'b01, 0);
        do_read(4'd3, 32'h40, 1, 2'b01);
        do_read(4'd4, 32'h1000, 0, 2'b01);
        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(0, 15);
            a = 32'($urandom_range(0, 1279) * 4);
            bu = 2'($urandom_range(0, 3));
            fill_rand(len);
            do_write(4'($urandom), a, len, bu, ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len);
            do_read(4'($urandom), a, len, bu);
        end
        fill_rand(31);
        fork
            do_write(4'd6, 32'h100, 31, 2'b01, 31);
            do_read(4'd7, 32'h800, 31, 2'b01);
        join
        do_read(4'd8, 32'h100, 31, 2'b01);
        // reset in the middle of a LEN 7 burst: beat 1 lands, beat 2 is cut off
        fill_rand(7);
        SLAVE_WR_ADDR_ID = 4'd3; SLAVE_WR_ADDR = 32'h200; SLAVE_WR_ADDR_LEN = 8'd7;
        SLAVE_WR_ADDR_BURST = 2'b01; SLAVE_WR_ADDR_VALID = 1'b1;
        for (int t = 0; t < 200 && !SLAVE_WR_ADDR_READY; t++) @(negedge clk);
        @(posedge clk); #1;
        SLAVE_WR_ADDR_VALID = 1'b0;
        SLAVE_WR_DATA = wdat[0]; SLAVE_WR_STRB = wstb[0]; SLAVE_WR_DATA_VALID = 1'b1;
        for (int t = 0; t < 200 && !SLAVE_WR_DATA_READY; t++) @(negedge clk);
        @(posedge clk);
        for (int b = 0; b < 4; b++) if (wstb[0][b]) model[128][8*b +: 8] = wdat[0][8*b +: 8];
        #1;
        SLAVE_WR_DATA = wdat[1]; SLAVE_WR_STRB = 4'hF;
        @(negedge clk);
        chk("w_ready_beat2", SLAVE_WR_DATA_READY, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outs", all_outs(), 64'd0);
        @(posedge clk); #1;
        SLAVE_WR_DATA_VALID = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_b_after_rst", SLAVE_WR_BACK_VALID, 0);
        end
        @(posedge clk); #1;
        fill_rand(0);
        do_write(4'd11, 32'h300, 0, 2'b01, 0);
        do_read(4'd12, 32'h200, 1, 2'b01);
        do_read(4'd13, 32'h300, 0, 2'b01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_slave_bram.md
AXI_SLAVE_BRAM -- requirements
Module: axi_slave_bram

Interface
REQ-001: MEM_DEPTH_LOG2, default 10: memory SHALL hold 2^MEM_DEPTH_LOG2 32-bit words.
REQ-002: BASE_ADDR, default 32'h0000_0000: byte address SHALL map to word 0; offset = addr - BASE_ADDR, word index = offset[MEM_DEPTH_LOG2+1:2].
REQ-003: clk  in  1  SHALL be the single clock.
REQ-004: rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005: SLAVE_WR_ADDR_ID  in  4  write address ID.
REQ-006: SLAVE_WR_ADDR  in  32  write start byte address.
REQ-007: SLAVE_WR_ADDR_LEN  in  8  write beats minus 1.
REQ-008: SLAVE_WR_ADDR_BURST  in  2  write burst type.
REQ-009: SLAVE_WR_ADDR_VALID  in  1  write address valid.
REQ-010: SLAVE_WR_ADDR_READY  out  1  write address ready.
REQ-011: SLAVE_WR_DATA  in  32  write data.
REQ-012: SLAVE_WR_STRB  in  4  byte enables, bit n -> data[8n+7:8n].
REQ-013: SLAVE_WR_DATA_LAST  in  1  last write beat flag.
REQ-014: SLAVE_WR_DATA_VALID  in  1  write data valid.
REQ-015: SLAVE_WR_DATA_READY  out  1  write data ready.
REQ-016: SLAVE_WR_BACK_ID  out  4  write response ID.
REQ-017: SLAVE_WR_BACK_RESP  out  2  write response, 00 OKAY, 10 SLVERR.
REQ-018: SLAVE_WR_BACK_VALID  out  1  write response valid.
REQ-019: SLAVE_WR_BACK_READY  in  1  write response ready.
REQ-020: SLAVE_RD_ADDR_ID  in  4  read address ID.
REQ-021: SLAVE_RD_ADDR  in  32  read start byte address.
REQ-022: SLAVE_RD_ADDR_LEN  in  8  read beats minus 1.
REQ-023: SLAVE_RD_ADDR_BURST  in  2  read burst type.
REQ-024: SLAVE_RD_ADDR_VALID  in  1  read address valid.
REQ-025: SLAVE_RD_ADDR_READY  out  1  read address ready.
REQ-026: SLAVE_RD_BACK_ID  out  4  read data ID.
REQ-027: SLAVE_RD_DATA  out  32  read data.
REQ-028: SLAVE_RD_DATA_RESP  out  2  read response, 00 OKAY, 10 SLVERR.
REQ-029: SLAVE_RD_DATA_LAST  out  1  last read beat flag.
REQ-030: SLAVE_RD_DATA_VALID  out  1  read data valid.
REQ-031: SLAVE_RD_DATA_READY  in  1  read data ready.

Function
REQ-032: Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE, with ADDR_READY=1 only in W_IDLE (AW handshake latches ID/addr/LEN/BURST and moves to W_DATA), DATA_READY=1 only in W_DATA, and BACK_VALID=1 only in W_RESP.
REQ-033: Each W handshake SHALL write the enabled bytes at the current index on that clk edge; address advances +4 for BURST 01 (INCR) and 10 (WRAP, treated as INCR), and holds for 00 (FIXED); 11 is treated as INCR.
REQ-034: Beat counter SHALL end W_DATA on beat LEN+1 regardless of DATA_LAST; if DATA_LAST does not coincide with beat LEN+1, BACK_RESP SHALL be 10, else 00; BACK_ID = latched AWID, held until BACK_READY.
REQ-035: Read FSM SHALL be R_IDLE -> R_FETCH -> R_DATA; ADDR_READY=1 only in R_IDLE, R_FETCH lasts one cycle for the synchronous RAM read, and R_DATA holds DATA_VALID=1 with stable DATA/ID/RESP/LAST until DATA_READY.
REQ-036: After a non-final R handshake, the FSM SHALL return to R_FETCH (one-cycle VALID gap, max 1 beat per 2 cycles); LAST=1 on beat LEN+1, whose handshake returns to R_IDLE.
REQ-037: Read and write channels SHALL operate concurrently; a same-word read fetch and write on the same edge SHALL return old data (read-first).
REQ-038: LEN=255 SHALL transfer 256 beats with no counter overflow; INCR past the top word behaves per REQ-042.

Reset
REQ-039: While rst=1, all READY/VALID/LAST outputs, IDs, RESP and RD_DATA SHALL be 0 and both FSMs idle; rst mid-burst aborts with no response, memory contents are not reset, and partially written beats persist.

Configuration
REQ-040: Macro AXI_BRAM_RANGE_CHECK_EN SHALL enable per-beat range checking.
REQ-041: When defined, a beat with offset >= 4*2^MEM_DEPTH_LOG2 or offset < 0 SHALL NOT write, SHALL make the whole write BACK_RESP 10 (sticky), and reads SHALL return DATA 0 with RESP 10 for that beat.
REQ-042: When undefined, the index SHALL wrap modulo depth and all responses SHALL be 00 except the DATA_LAST error.

Verification
REQ-043: AW addr 0x10 LEN 3 INCR ID 5, W 0xA0..0xA3 STRB F, LAST on beat 4 -> BACK_RESP 00 ID 5; read of same range returns A0..A3 with LAST on 4th beat.
REQ-044: Write 0xFFFFFFFF to 0x0, then STRB 4'b0010 data 0x00001200 -> read 0x0 = 0xFFFF12FF.
REQ-045: FIXED burst LEN 2 to 0x8 with data 1,2,3 -> word 0x8 reads 3, 0xC unchanged.
REQ-046: LEN 1 with DATA_LAST on beat 1 -> two beats still accepted, BACK_RESP 10.
REQ-047: With macro, read at 0x1000 (depth 1024) -> DATA 0, RESP 10; without macro -> word 0 data, RESP 00.
REQ-048: rst asserted during beat 2 of a LEN 7 write -> all outputs 0 asynchronously, no BACK_VALID, next AW accepted after release.
